// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem -- memory stage of an in-order RISC-V style pipeline.
//
// Takes the execute-stage result and either forwards it to write-back after one
// cycle (non-memory ops and misaligned accesses) or runs one classic Wishbone
// data-bus cycle for an aligned LOAD/STORE. It stalls execute until the bus
// answers, then retires with load data or an access fault.
//
// Build option:
//   BUS_TIMEOUT_EN  -- when defined, a bus cycle with no ack/err after
//                      TIMEOUT_CYCLES WAIT cycles is retired as an access fault.
//                      When undefined the stage waits for ack/err indefinitely.
//
// Ports:
//   clk_i, rst_i                      clock (rising edge), async active-low reset
//   valid_i, pc_i, instruction_i,     execute-stage result; held stable by the
//   funct3_i, alu_d_i, rs2_d_i        execute stage while stall_o is high
//   e_illegal_inst_i,                 upstream exceptions, passed through
//   e_inst_addr_mis_i
//   flush_i                           kill stage contents (exception in WB)
//   stall_o                           hold the execute stage
//   dwbm_*                            Wishbone data-bus master
//   valid_o .. e_access_fault_o       write-back registers
// -----------------------------------------------------------------------------
module stage_mem #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instruction_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_d_i,
    input  logic [31:0] rs2_d_i,
    input  logic        e_illegal_inst_i,
    input  logic        e_inst_addr_mis_i,
    input  logic        flush_i,
    output logic        stall_o,

    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i,

    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic [31:0] alu_d_o,
    output logic [31:0] mem_d_o,
    output logic [31:0] mem_addr_o,
    output logic [2:0]  funct3_o,
    output logic        e_illegal_inst_o,
    output logic        e_inst_addr_mis_o,
    output logic        e_ld_addr_mis_o,
    output logic        e_st_addr_mis_o,
    output logic        e_access_fault_o
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t state, state_nxt;

    // Registered bus strobes; the ports gate them with flush_i so an aborted
    // cycle disappears in the same clock the flush is raised.
    logic cyc_q, stb_q;

    // ---------------------------------------------------------------- decode
    logic is_load, is_store, misaligned, mem_go;
    logic timeout, bus_done;

    assign is_load    = (instruction_i[6:0] == OPC_LOAD);
    assign is_store   = (instruction_i[6:0] == OPC_STORE);
    assign misaligned = ((funct3_i[1:0] == 2'b01) && alu_d_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (alu_d_i[1:0] != 2'b00));
    assign mem_go     = valid_i && (is_load || is_store) && !misaligned && !flush_i;
    assign bus_done   = dwbm_ack_i || dwbm_err_i || timeout;

    // --------------------------------------------------------------- timeout
`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts completed WAIT cycles; the Nth WAIT cycle is the timeout cycle.
    assign timeout = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && (state_nxt == ST_WAIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    // No timeout in this build; the parameter only matters with the counter.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_go) begin
                    state_nxt = ST_WAIT;
                    stall_o   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (flush_i || bus_done) state_nxt = ST_IDLE;
                else                     stall_o   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // The execute stage must be free to move while reset is held.
        if (!rst_i) stall_o = 1'b0;
    end

    // ------------------------------------------------------- bus formatting
    logic [3:0]  sel_nxt;
    logic [31:0] dat_nxt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        sel_nxt = 4'b1111;
        dat_nxt = 32'h0;
        if (is_store) begin
            case (funct3_i[1:0])
                2'b00: begin
                    sel_nxt = 4'b0001 << alu_d_i[1:0];
                    dat_nxt = {4{rs2_d_i[7:0]}};
                end
                2'b01: begin
                    sel_nxt = 4'b0011 << alu_d_i[1:0];
                    dat_nxt = {2{rs2_d_i[15:0]}};
                end
                default: begin
                    sel_nxt = 4'b1111;
                    dat_nxt = rs2_d_i;
                end
            endcase
        end
    end

    // Execute is stalled during WAIT, so funct3_i/alu_d_i still describe the
    // access in flight when the ack arrives.
    assign ld_byte = dwbm_dat_i[{alu_d_i[1:0], 3'b000} +: 8];
    assign ld_half = alu_d_i[1] ? dwbm_dat_i[31:16] : dwbm_dat_i[15:0];

    always_comb begin
        case (funct3_i)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dwbm_dat_i;
        endcase
    end

    assign dwbm_cyc_o = cyc_q && !flush_i;
    assign dwbm_stb_o = stb_q && !flush_i;

    // ------------------------------------------- bus and write-back registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cyc_q             <= 1'b0;
            stb_q             <= 1'b0;
            dwbm_addr_o       <= '0;
            dwbm_dat_o        <= '0;
            dwbm_sel_o        <= '0;
            dwbm_we_o         <= 1'b0;
            valid_o           <= 1'b0;
            pc_o              <= '0;
            instruction_o     <= '0;
            alu_d_o           <= '0;
            mem_d_o           <= '0;
            mem_addr_o        <= '0;
            funct3_o          <= '0;
            e_illegal_inst_o  <= 1'b0;
            e_inst_addr_mis_o <= 1'b0;
            e_ld_addr_mis_o   <= 1'b0;
            e_st_addr_mis_o   <= 1'b0;
            e_access_fault_o  <= 1'b0;
        end else if (flush_i) begin
            // Abort: any later bus response lands in IDLE and is ignored.
            cyc_q             <= 1'b0;
            stb_q             <= 1'b0;
            valid_o           <= 1'b0;
            e_illegal_inst_o  <= 1'b0;
            e_inst_addr_mis_o <= 1'b0;
            e_ld_addr_mis_o   <= 1'b0;
            e_st_addr_mis_o   <= 1'b0;
            e_access_fault_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_go) begin
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        dwbm_addr_o <= {alu_d_i[31:2], 2'b00};
                        dwbm_we_o   <= is_store;
                        dwbm_sel_o  <= sel_nxt;
                        dwbm_dat_o  <= dat_nxt;
                        valid_o     <= 1'b0;
                    end else if (valid_i) begin
                        // Non-memory op or misaligned access: retire now.
                        valid_o           <= 1'b1;
                        pc_o              <= pc_i;
                        instruction_o     <= instruction_i;
                        funct3_o          <= funct3_i;
                        alu_d_o           <= alu_d_i;
                        mem_d_o           <= '0;
                        mem_addr_o        <= alu_d_i;
                        e_illegal_inst_o  <= e_illegal_inst_i;
                        e_inst_addr_mis_o <= e_inst_addr_mis_i;
                        e_ld_addr_mis_o   <= is_load && misaligned;
                        e_st_addr_mis_o   <= is_store && misaligned;
                        e_access_fault_o  <= 1'b0;
                    end else begin
                        valid_o           <= 1'b0;
                        e_illegal_inst_o  <= 1'b0;
                        e_inst_addr_mis_o <= 1'b0;
                        e_ld_addr_mis_o   <= 1'b0;
                        e_st_addr_mis_o   <= 1'b0;
                        e_access_fault_o  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus_done) begin
                        cyc_q             <= 1'b0;
                        stb_q             <= 1'b0;
                        valid_o           <= 1'b1;
                        pc_o              <= pc_i;
                        instruction_o     <= instruction_i;
                        funct3_o          <= funct3_i;
                        alu_d_o           <= alu_d_i;
                        mem_addr_o        <= alu_d_i;
                        e_illegal_inst_o  <= e_illegal_inst_i;
                        e_inst_addr_mis_o <= e_inst_addr_mis_i;
                        e_ld_addr_mis_o   <= 1'b0;
                        e_st_addr_mis_o   <= 1'b0;
                        // err wins over a simultaneous ack.
                        if (dwbm_err_i || timeout) begin
                            e_access_fault_o <= 1'b1;
                            mem_d_o          <= '0;
                        end else begin
                            e_access_fault_o <= 1'b0;
                            mem_d_o          <= is_load ? ld_data : 32'h0;
                        end
                    end else begin
                        valid_o <= 1'b0;
                    end
                end
                default: valid_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// -----------------------------------------------------------------------------
// tb_stage_mem -- directed self-checking bench for stage_mem.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// The timeout scenario is compiled in only when BUS_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_stage_mem;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i, instruction_i, alu_d_i, rs2_d_i;
    logic [2:0]  funct3_i;
    logic        e_illegal_inst_i, e_inst_addr_mis_i, flush_i;
    logic        stall_o;
    logic [31:0] dwbm_addr_o, dwbm_dat_o, dwbm_dat_i;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_we_o, dwbm_cyc_o, dwbm_stb_o, dwbm_ack_i, dwbm_err_i;
    logic        valid_o;
    logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
    logic [2:0]  funct3_o;
    logic        e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o;
    logic        e_st_addr_mis_o, e_access_fault_o;

    int n_tests = 0;
    int n_fail  = 0;

    stage_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .valid_i           (valid_i),
        .pc_i              (pc_i),
        .instruction_i     (instruction_i),
        .funct3_i          (funct3_i),
        .alu_d_i           (alu_d_i),
        .rs2_d_i           (rs2_d_i),
        .e_illegal_inst_i  (e_illegal_inst_i),
        .e_inst_addr_mis_i (e_inst_addr_mis_i),
        .flush_i           (flush_i),
        .stall_o           (stall_o),
        .dwbm_addr_o       (dwbm_addr_o),
        .dwbm_dat_o        (dwbm_dat_o),
        .dwbm_sel_o        (dwbm_sel_o),
        .dwbm_we_o         (dwbm_we_o),
        .dwbm_cyc_o        (dwbm_cyc_o),
        .dwbm_stb_o        (dwbm_stb_o),
        .dwbm_dat_i        (dwbm_dat_i),
        .dwbm_ack_i        (dwbm_ack_i),
        .dwbm_err_i        (dwbm_err_i),
        .valid_o           (valid_o),
        .pc_o              (pc_o),
        .instruction_o     (instruction_o),
        .alu_d_o           (alu_d_o),
        .mem_d_o           (mem_d_o),
        .mem_addr_o        (mem_addr_o),
        .funct3_o          (funct3_o),
        .e_illegal_inst_o  (e_illegal_inst_o),
        .e_inst_addr_mis_o (e_inst_addr_mis_o),
        .e_ld_addr_mis_o   (e_ld_addr_mis_o),
        .e_st_addr_mis_o   (e_st_addr_mis_o),
        .e_access_fault_o  (e_access_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2);
        valid_i       = 1'b1;
        instruction_i = {20'hABCDE, 5'd0, opc};
        funct3_i      = f3;
        alu_d_i       = addr;
        rs2_d_i       = rs2;
    endtask

    // Aligned load answered with ack in the first WAIT cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] dat, input logic [31:0] exp);
        set_op(OPC_LOAD, f3, addr, 32'h0);
        step();
        check({tag, "_cyc"}, dwbm_cyc_o, 1'b1);
        dwbm_ack_i = 1'b1;
        dwbm_dat_i = dat;
        step();
        dwbm_ack_i = 1'b0;
        valid_i    = 1'b0;
        check({tag, "_data"}, mem_d_o, exp);
        step();
    endtask

    // Aligned store: check the bus lanes, then ack and check retirement.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [3:0] exp_sel,
                            input logic [31:0] exp_dat);
        set_op(OPC_STORE, f3, addr, rs2);
        step();
        check({tag, "_sel"}, dwbm_sel_o, exp_sel);
        check({tag, "_dat"}, dwbm_dat_o, exp_dat);
        check({tag, "_we"},  dwbm_we_o, 1'b1);
        check({tag, "_adr"}, dwbm_addr_o, {addr[31:2], 2'b00});
        dwbm_ack_i = 1'b1;
        step();
        dwbm_ack_i = 1'b0;
        valid_i    = 1'b0;
        check({tag, "_vld"}, valid_o, 1'b1);
        check({tag, "_memd"}, mem_d_o, 32'h0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        valid_i = 1'b0; pc_i = '0; instruction_i = '0; funct3_i = '0;
        alu_d_i = '0; rs2_d_i = '0; e_illegal_inst_i = 1'b0; e_inst_addr_mis_i = 1'b0;
        flush_i = 1'b0; dwbm_dat_i = '0; dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0;

        // ---- reset: aligned load presented while reset is held
        set_op(OPC_LOAD, 3'b010, 32'h100, 32'h0);
        #2;
        check("rst_stall", stall_o, 1'b0);
        #20;
        check("rst_valid", valid_o, 1'b0);
        check("rst_cyc",   dwbm_cyc_o, 1'b0);
        check("rst_sel",   dwbm_sel_o, 4'h0);
        check("rst_addr",  dwbm_addr_o, 32'h0);
        check("rst_pc",    pc_o, 32'h0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        step();

        // ---- non-memory op, latency 1, no bus cycle
        pc_i = 32'h1000;
        set_op(OPC_OP, 3'b000, 32'h1234, 32'h0);
        #1;
        check("op_stall", stall_o, 1'b0);
        step();
        check("op_valid", valid_o, 1'b1);
        check("op_alu",   alu_d_o, 32'h1234);
        check("op_inst",  instruction_o, 32'hABCDE033);
        check("op_pc",    pc_o, 32'h1000);
        check("op_memd",  mem_d_o, 32'h0);
        check("op_cyc",   dwbm_cyc_o, 1'b0);
        valid_i = 1'b0;
        step();
        check("idle_valid", valid_o, 1'b0);
        check("idle_alu",   alu_d_o, 32'h1234);

        // ---- LB 0x103, ack after 2 wait cycles
        pc_i = 32'h1004;
        set_op(OPC_LOAD, 3'b000, 32'h103, 32'h0);
        #1;
        check("lb_stall1", stall_o, 1'b1);
        check("lb_nocyc",  dwbm_cyc_o, 1'b0);
        step();
        check("lb_stall2", stall_o, 1'b1);
        check("lb_cyc",    dwbm_cyc_o, 1'b1);
        check("lb_stb",    dwbm_stb_o, 1'b1);
        check("lb_addr",   dwbm_addr_o, 32'h100);
        check("lb_sel",    dwbm_sel_o, 4'b1111);
        check("lb_we",     dwbm_we_o, 1'b0);
        check("lb_wvalid", valid_o, 1'b0);
        check("lb_hold",   alu_d_o, 32'h1234);
        step();
        check("lb_stall3", stall_o, 1'b1);
        dwbm_ack_i = 1'b1;
        dwbm_dat_i = 32'h80FFFFFF;
        #1;
        check("lb_stall_ack", stall_o, 1'b0);
        step();
        dwbm_ack_i = 1'b0;
        valid_i    = 1'b0;
        check("lb_valid", valid_o, 1'b1);
        check("lb_memd",  mem_d_o, 32'hFFFFFF80);
        check("lb_maddr", mem_addr_o, 32'h103);
        check("lb_pc",    pc_o, 32'h1004);
        check("lb_cyc_off", dwbm_cyc_o, 1'b0);
        step();

        // ---- load extension table
        do_load("lbu", 3'b100, 32'h100, 32'h12F456F7, 32'h000000F7);
        do_load("lb1", 3'b000, 32'h101, 32'h12F47F00, 32'h0000007F);
        do_load("lh",  3'b001, 32'h102, 32'h80FF1234, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h100, 32'h80FF9234, 32'h00009234);
        do_load("lw",  3'b010, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF);

        // ---- stores
        do_store("sh", 3'b001, 32'h202, 32'h0000ABCD, 4'b1100, 32'hABCDABCD);
        do_store("sb", 3'b000, 32'h203, 32'h0000005A, 4'b1000, 32'h5A5A5A5A);

        // ---- misaligned LW and SH: retire in 1 cycle, no bus cycle
        set_op(OPC_LOAD, 3'b010, 32'h101, 32'h0);
        #1;
        check("lwmis_stall", stall_o, 1'b0);
        step();
        check("lwmis_cyc",   dwbm_cyc_o, 1'b0);
        check("lwmis_flag",  e_ld_addr_mis_o, 1'b1);
        check("lwmis_st",    e_st_addr_mis_o, 1'b0);
        check("lwmis_maddr", mem_addr_o, 32'h101);
        check("lwmis_valid", valid_o, 1'b1);
        set_op(OPC_STORE, 3'b001, 32'h203, 32'h0);
        step();
        check("shmis_flag", e_st_addr_mis_o, 1'b1);
        check("shmis_ld",   e_ld_addr_mis_o, 1'b0);
        valid_i = 1'b0;
        step();
        check("mis_clear", e_st_addr_mis_o, 1'b0);

        // ---- SW with bus error
        set_op(OPC_STORE, 3'b010, 32'h300, 32'h11223344);
        step();
        check("swerr_dat", dwbm_dat_o, 32'h11223344);
        check("swerr_sel", dwbm_sel_o, 4'b1111);
        dwbm_err_i = 1'b1;
        dwbm_ack_i = 1'b1;
        #1;
        check("swerr_stall", stall_o, 1'b0);
        step();
        dwbm_err_i = 1'b0;
        dwbm_ack_i = 1'b0;
        valid_i    = 1'b0;
        check("swerr_valid", valid_o, 1'b1);
        check("swerr_fault", e_access_fault_o, 1'b1);
        check("swerr_maddr", mem_addr_o, 32'h300);
        step();
        check("swerr_clear", e_access_fault_o, 1'b0);

        // ---- flush mid-WAIT, then a stale ack that must be ignored
        set_op(OPC_LOAD, 3'b010, 32'h400, 32'h0);
        step();
        check("fl_cyc_on", dwbm_cyc_o, 1'b1);
        flush_i = 1'b1;
        #1;
        check("fl_cyc_drop", dwbm_cyc_o, 1'b0);
        check("fl_stb_drop", dwbm_stb_o, 1'b0);
        check("fl_stall",    stall_o, 1'b0);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("fl_valid", valid_o, 1'b0);
        dwbm_ack_i = 1'b1;
        dwbm_dat_i = 32'hFFFFFFFF;
        step();
        dwbm_ack_i = 1'b0;
        check("fl_stale_valid", valid_o, 1'b0);
        check("fl_stale_cyc",   dwbm_cyc_o, 1'b0);
        check("fl_stale_memd",  mem_d_o, 32'h0);

        // ---- asynchronous reset during a bus cycle
        set_op(OPC_LOAD, 3'b010, 32'h600, 32'h0);
        step();
        check("ar_cyc_on", dwbm_cyc_o, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        check("ar_cyc",   dwbm_cyc_o, 1'b0);
        check("ar_stall", stall_o, 1'b0);
        check("ar_addr",  dwbm_addr_o, 32'h0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        check("ar_idle_cyc", dwbm_cyc_o, 1'b0);

`ifdef BUS_TIMEOUT_EN
        // ---- no response: fault after 4 WAIT cycles
        set_op(OPC_LOAD, 3'b010, 32'h500, 32'h0);
        step();
        check("to_stall_w1", stall_o, 1'b1);
        step();
        check("to_stall_w2", stall_o, 1'b1);
        step();
        check("to_stall_w3", stall_o, 1'b1);
        check("to_valid_w3", valid_o, 1'b0);
        step();
        check("to_stall_w4", stall_o, 1'b0);
        step();
        valid_i = 1'b0;
        check("to_valid", valid_o, 1'b1);
        check("to_fault", e_access_fault_o, 1'b1);
        check("to_cyc",   dwbm_cyc_o, 1'b0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max bus-wait cycles before abort (used only with BUS_TIMEOUT_EN).
REQ-002 SHALL have clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have valid_i  in  1  execute-stage result present; pc_i / instruction_i  in  32 each; funct3_i  in  3; alu_d_i  in  32  ALU result / effective address; rs2_d_i  in  32  store data.
REQ-005 SHALL have e_illegal_inst_i, e_inst_addr_mis_i  in  1 each  upstream exceptions, passed through.
REQ-006 SHALL have flush_i  in  1  exception taken in write-back; kill stage contents.
REQ-007 SHALL have stall_o  out  1  hold execute stage.
REQ-008 SHALL have data bus master ports: dwbm_addr_o  out  32; dwbm_dat_o  out  32; dwbm_sel_o  out  4; dwbm_we_o, dwbm_cyc_o, dwbm_stb_o  out  1 each; dwbm_dat_i  in  32; dwbm_ack_i, dwbm_err_i  in  1 each.
REQ-009 SHALL have write-back outputs: valid_o  out  1; pc_o / instruction_o / alu_d_o / mem_d_o / mem_addr_o  out  32 each; funct3_o  out  3; e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_access_fault_o  out  1 each.

Function
REQ-010 SHALL decode LOAD (0000011) and STORE (0100011) from instruction_i[6:0]; all other opcodes are non-memory.
REQ-011 SHALL pass a non-memory instruction to the write-back registers on the next rising edge (latency 1), with mem_d_o = 0.
REQ-012 SHALL flag misalignment when funct3[1:0]=01 and addr[0]=1, or funct3[1:0]=10 and addr[1:0]!=0; such access starts no bus cycle; outputs update in 1 cycle with e_ld_addr_mis_o or e_st_addr_mis_o = 1 and mem_addr_o = alu_d_i.
REQ-013 SHALL use FSM states IDLE and WAIT: IDLE->WAIT on valid_i & aligned memory op & !flush_i; WAIT->IDLE on dwbm_ack_i, dwbm_err_i, timeout, or flush_i.
REQ-014 SHALL, on IDLE->WAIT, register dwbm_addr_o = {alu_d_i[31:2],2'b00}, dwbm_we_o = STORE, and assert dwbm_cyc_o = dwbm_stb_o = 1 from the next cycle until the cycle ack/err is sampled inclusive.
REQ-015 SHALL set store dwbm_sel_o: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; dwbm_dat_o = rs2 byte/halfword replicated across lanes (SB {4{b}}, SH {2{h}}); loads drive sel 1111.
REQ-016 SHALL, on ack for a load, form mem_d_o from dwbm_dat_i by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; valid_o = 1 the following cycle (aligned memory op latency = bus wait + 2).
REQ-017 SHALL assert stall_o = (IDLE & valid_i & aligned memory op & !flush_i) | (WAIT & !dwbm_ack_i & !dwbm_err_i & !flush_i).
REQ-018 SHALL, on dwbm_err_i in WAIT, retire the instruction with e_access_fault_o = 1 and mem_addr_o = alu address; ack and err together are treated as err.
REQ-019 SHALL, on flush_i, drop cyc/stb the same cycle, return to IDLE, and clear valid_o and all e_*_o on the next edge; the bus response to an aborted cycle is ignored.
REQ-020 SHALL hold write-back outputs unchanged while stall_o = 1, except valid_o = 0 during WAIT.
REQ-021 SHALL, when valid_i = 0 and not stalled, clear valid_o and all e_*_o on the next edge.

Reset
REQ-022 SHALL, while rst_i = 0, force state IDLE, timeout counter 0, and every output register (valid_o, pc_o, instruction_o, funct3_o, alu_d_o, mem_d_o, mem_addr_o, all e_*_o, dwbm_*_o) to 0, independent of clk_i.
REQ-023 SHALL abandon an in-flight bus cycle on reset with no further action; stall_o = 0 during reset.

Configuration
REQ-024 SHALL, with BUS_TIMEOUT_EN defined, count WAIT cycles; reaching TIMEOUT_CYCLES with no ack/err retires the access as REQ-018 (e_access_fault_o = 1).
REQ-025 SHALL, without BUS_TIMEOUT_EN, omit the counter, wait indefinitely in WAIT, and tie e_access_fault_o to err-only behaviour.

Verification
REQ-026 SHALL cover: OP result 0x1234 valid_i -> valid_o = 1, alu_d_o = 0x1234 after 1 cycle, no cyc.
REQ-027 SHALL cover: LB addr 0x103, ack after 2 waits with dat 0x80FFFFFF -> sel 1111, mem_d_o = 0xFFFFFF80, stall_o high 3 cycles.
REQ-028 SHALL cover: SH addr 0x202, rs2 0xABCD -> dwbm_sel_o = 1100, dwbm_dat_o = 0xABCDABCD, we = 1.
REQ-029 SHALL cover: LW addr 0x101 -> no cyc, e_ld_addr_mis_o = 1, mem_addr_o = 0x101 after 1 cycle.
REQ-030 SHALL cover: dwbm_err_i during SW -> e_access_fault_o = 1; flush_i mid-WAIT -> cyc drops same cycle, valid_o = 0; with BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> fault after 4 WAIT cycles.
